// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the IF/MEM unified memory port arbiter.
package mem_arb_pkg;

   localparam int LAT_CNT_W = 4;

   typedef enum logic {
      ARB_IDLE,
      ARB_BUSY
   } arb_state_t;

   typedef enum logic {
      OWN_IF,
      OWN_MEM
   } arb_owner_t;

   function automatic logic [LAT_CNT_W-1:0] lat_load(input int lat);
      return LAT_CNT_W'(lat);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_starve.sv
// arb_starve_ctr: saturating count of MEM grants made while IF waits.
// Used by mem_port_arbiter only when MEM_ARB_STARVE_GUARD_EN is defined.
module arb_starve_ctr
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic grant_if,
   input  logic grant_mem,
   input  logic if_pending,
   output logic force_if
);

   localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_MAX);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (grant_if) begin
         cnt <= '0;
      end else if (grant_mem && if_pending && cnt != LIM) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign force_if = (cnt == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between IF and MEM.
// Define MEM_ARB_STARVE_GUARD_EN to bound how long MEM may starve IF.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_valid,
   output logic                if_stall,
   input  logic                mem_req,
   input  logic                mem_we,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W/8-1:0] mem_be,
   output logic [DATA_W-1:0]   mem_rdata,
   output logic                mem_valid,
   output logic                mem_stall,
   output logic                m_req,
   output logic                m_we,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_be,
   input  logic [DATA_W-1:0]   m_rdata,
   output logic                busy
);

   localparam logic [LAT_CNT_W-1:0] LAT = lat_load(MEM_LAT);
   localparam logic [LAT_CNT_W-1:0] ONE = LAT_CNT_W'(1);

   arb_state_t           state, state_nx;
   arb_owner_t           owner, owner_nx;
   logic [LAT_CNT_W-1:0] cnt, cnt_nx;
   logic                 cancel, cancel_nx;

   logic if_q, mem_q;
   logic pick_if, pick_mem;
   logic grant_if, grant_mem;
   logic force_if;
   logic own_req, done, deliver;

   // Holding reset low masks requests, so every output collapses to 0.
   assign if_q  = if_req & reset;
   assign mem_q = mem_req & reset;

`ifdef MEM_ARB_STARVE_GUARD_EN
   arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk        (clk),
      .reset      (reset),
      .grant_if   (grant_if),
      .grant_mem  (grant_mem),
      .if_pending (if_q),
      .force_if   (force_if)
   );
`else
   // Strict MEM priority; only a nonsensical STARVE_MAX flips this.
   assign force_if = (STARVE_MAX < 1);
`endif

   assign pick_if  = if_q & (force_if | ~mem_q);
   assign pick_mem = mem_q & ~pick_if;

   assign own_req = (owner == OWN_MEM) ? mem_q : if_q;

   always_comb begin
      state_nx  = state;
      owner_nx  = owner;
      cnt_nx    = cnt;
      cancel_nx = cancel;
      grant_if  = 1'b0;
      grant_mem = 1'b0;
      done      = 1'b0;
      unique case (state)
         ARB_IDLE: begin
            unique case (1'b1)
               pick_mem: begin
                  grant_mem = 1'b1;
                  owner_nx  = OWN_MEM;
               end
               pick_if: begin
                  grant_if = 1'b1;
                  owner_nx = OWN_IF;
               end
               default: ;
            endcase
            if (grant_if | grant_mem) begin
               state_nx  = ARB_BUSY;
               cnt_nx    = LAT;
               cancel_nx = 1'b0;
            end
         end
         ARB_BUSY: begin
            cnt_nx = cnt - ONE;
            if (!own_req) begin
               cancel_nx = 1'b1;
            end
            if (cnt == ONE) begin
               done     = 1'b1;
               state_nx = ARB_IDLE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= ARB_IDLE;
         owner  <= OWN_IF;
         cnt    <= '0;
         cancel <= 1'b0;
      end else begin
         state  <= state_nx;
         owner  <= owner_nx;
         cnt    <= cnt_nx;
         cancel <= cancel_nx;
      end
   end

   // A withdrawn owner still lets the access drain; only the reply is dropped.
   assign deliver = done & ~cancel & own_req;

   assign if_valid  = deliver & (owner == OWN_IF);
   assign mem_valid = deliver & (owner == OWN_MEM);
   assign if_rdata  = if_valid ? m_rdata : '0;
   assign mem_rdata = mem_valid ? m_rdata : '0;
   assign if_stall  = if_q & ~if_valid;
   assign mem_stall = mem_q & ~mem_valid;

   assign m_req   = grant_if | grant_mem;
   assign m_we    = grant_mem & mem_we;
   assign m_addr  = grant_mem ? mem_addr :
                    grant_if  ? if_addr  : '0;
   assign m_wdata = grant_mem ? mem_wdata : '0;
   assign m_be    = grant_mem ? mem_be : '0;

   assign busy = reset & (state == ARB_BUSY);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-ported unified memory between the pipeline's instruction-fetch (IF) stage and data-memory (MEM) stage.
- Arbitrates per access, tracks the fixed memory latency with a counter, and returns each response to the requester that issued it.
- Produces per-stage stall signals, which `pipelined_top` ORs into its existing hazard stalls.

## Interface

Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `DATA_W/8` byte enables
- `MEM_LAT`, 2, cycles from issue to read data/ack valid; legal range 1..15
- `STARVE_MAX`, 4, consecutive MEM grants allowed while `if_req` pends (used only with guard, legal ≥1)

Ports (clocking: reset `reset`, synchronous, active-low; clock `clk`):
- `clk` in 1: clock, rising edge
- `reset` in 1: synchronous, active-low
- `if_req` in 1: fetch request, held until `if_valid` or withdrawn (flush)
- `if_addr` in ADDR_W: fetch address, stable while `if_req`
- `if_rdata` out DATA_W: fetch data, valid only with `if_valid`, else 0
- `if_valid` out 1: one-cycle fetch completion pulse
- `if_stall` out 1: `if_req & ~if_valid`
- `mem_req` in 1: load/store request, held until `mem_valid`
- `mem_we` in 1: 1 = store
- `mem_addr` in ADDR_W: data address
- `mem_wdata` in DATA_W: store data
- `mem_be` in DATA_W/8: byte enables
- `mem_rdata` out DATA_W: load data with `mem_valid`, else 0
- `mem_valid` out 1: one-cycle completion pulse (loads and stores)
- `mem_stall` out 1: `mem_req & ~mem_valid`
- `m_req` out 1: memory issue strobe, one cycle per access
- `m_we` out 1: memory write enable
- `m_addr` out ADDR_W: memory address
- `m_wdata` out DATA_W: memory write data
- `m_be` out DATA_W/8: memory byte enables
- `m_rdata` in DATA_W: memory read data, valid exactly MEM_LAT cycles after `m_req`
- `busy` out 1: a transaction is outstanding (state ARB_BUSY)

## Operation

- **States:**
  - ARB_IDLE: no access outstanding.
  - ARB_BUSY: one access outstanding, with latched owner (OWN_IF/OWN_MEM), `cancel` flag, and down-counter `cnt`.
- **Grant in ARB_IDLE:**
  - `mem_req` wins over `if_req`, because MEM holds the older instruction.
  - With a request present, the arbiter drives `m_*` combinationally from the granted requester's inputs with `m_req`=1.
  - At the clock edge it latches owner, sets `cnt`=MEM_LAT, clears `cancel`, and moves to ARB_BUSY.
- **ARB_BUSY:**
  - `cnt` decrements every cycle; `m_req`=0; the `m_*` data/address outputs are 0.
  - When `cnt`==1, the completion cycle occurs:
    - The owner's valid pulses and its rdata equals `m_rdata`, unless `cancel` is set or the owner's req is low this cycle.
    - Next state is ARB_IDLE.
  - No issue is made in the completion cycle, so one access occupies MEM_LAT+1 cycles minimum.
- **Withdrawal:**
  - If the owner's req is low in any ARB_BUSY cycle, `cancel` is set.
  - The memory transaction still runs to completion; its response is dropped (no valid pulse).
  - This is how the IF flush on a taken branch is handled.
  - MEM withdrawal is a protocol violation but is handled identically.
- **Stalls:** a requester that is not granted, or is granted but not yet complete, sees stall=1.
- **Reset:**
  - While `reset`=0, all outputs are forced to 0, including the stalls.
  - On the first edge with `reset`=0: state ARB_IDLE, owner OWN_IF, `cnt`=0, `cancel`=0, starvation counter 0.
  - Reset mid-transaction abandons the transaction; memory data returning later is ignored.

## Timing

- Issue at cycle t → valid at t+MEM_LAT → earliest next issue at t+MEM_LAT+1.
- Stall is asserted from t (or from the request cycle if the requester is waiting) through t+MEM_LAT−1, and is low at t+MEM_LAT.
- `m_*` and stalls are combinational from requests and state; `busy` is registered.

## Configuration

- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A starvation counter increments on each MEM grant made while `if_req`=1 and is cleared on each IF grant.
  - When it equals STARVE_MAX, the next arbitration grants IF even if `mem_req`=1.
- Undefined: strict MEM priority, and no counter logic is generated.

## Structure

- The shared package `mem_arb_pkg` holds:
  - `arb_state_t` {ARB_IDLE, ARB_BUSY}
  - `arb_owner_t` {OWN_IF, OWN_MEM}
  - `LAT_CNT_W` = 4
- One sub-module is natural: `arb_starve_ctr`, the saturating starvation counter with `grant_if`/`grant_mem`/`if_pending` inputs and a `force_if` output. It is instantiated only under the macro.

## Test plan

All scenarios use MEM_LAT=2 and STARVE_MAX=4.
1. **Single fetch:** `if_req`, `if_addr`=0x10 at t; `m_rdata`=0x00500093 at t+2 → `m_req`=1 and `m_addr`=0x10 at t; `if_stall`=1 at t and t+1; `if_valid`=1 with `if_rdata`=0x00500093 at t+2.
2. **Simultaneous requests:** `if_req` and `mem_req` at t → MEM issued at t, `mem_valid` at t+2, IF issued at t+3, `if_valid` at t+5, `if_stall` high from t through t+4.
3. **Store:** `mem_we`=1, `mem_addr`=0x100, `mem_wdata`=0xDEADBEEF, `mem_be`=4'b0011 → same values on `m_*` at t with `m_we`=1; `mem_valid` at t+2; `mem_rdata`=0 outside the valid cycle.
4. **Flush:** IF issued at t, `if_req` dropped at t+1 → no `if_valid` at t+2, `busy`=0 at t+3, a new `if_req` at t+3 is issued at t+3.
5. **Starvation:** `mem_req` and `if_req` held continuously. With the macro: 4 MEM grants, then an IF grant on the 5th arbitration. Without the macro: IF is never granted.
6. **Reset mid-transaction:** `reset`=0 at t+1 → all outputs 0 during reset, no valid at t+2, state ARB_IDLE after reset release.
